can_brs_ctrl: RTL and testbench

Controls the CAN FD bit-rate switch for the receive path. It tracks frame phase from bit-level strobes issued by the bit stream processor, and drives `data_phase` to the bit timing logic, which selects nominal or FD data timing. It also holds the shadow FD timing configuration and applies it to the bit timing logic only while the bus is idle. An optional watchdog forces a return to nominal rate if the data phase runs too long.

---
 rtl/can_brs_ctrl_if.sv | 55 +++++
 rtl/can_brs_ctrl.sv | 152 +++++++++++++++
 tb/tb_can_brs_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/can_brs_ctrl_if.sv
// Signal bundle between the bit stream processor / host side (master) and
// the CAN FD bit-rate switch controller (slave).
interface can_brs_ctrl_if;
  logic       sample_point;
  logic       sampled_bit;
  logic       en_FD_rx;
  logic       sof_bit;
  logic       fdf_bit;
  logic       brs_bit;
  logic       crc_delim_bit;
  logic       go_error_frame;
  logic       bus_idle;
  logic       cfg_wr_req;
  logic [5:0] cfg_prop_seg_fd;
  logic [4:0] cfg_phase_seg_1_fd;
  logic [4:0] cfg_phase_seg_2_fd;
  logic [6:0] cfg_baud_r_presc_fd;
  logic [4:0] cfg_sjw_fd;
  logic       cfg_triple_sampling_fd;
  logic       cfg_wr_ack;
  logic       cfg_wr_err;
  logic [5:0] prop_seg_fd;
  logic [4:0] phase_seg_1_fd;
  logic [4:0] phase_seg_2_fd;
  logic [6:0] baud_r_presc_fd;
  logic [4:0] sjw_fd;
  logic       triple_sampling_fd;
  logic       data_phase;
  logic       fd_frame;
  logic       brs_on;
  logic       brs_off;
  logic [9:0] data_bit_cnt;
  logic       wdog_timeout;
  logic [2:0] dbg_state;

  modport master (
    output sample_point, sampled_bit, en_FD_rx, sof_bit, fdf_bit, brs_bit,
           crc_delim_bit, go_error_frame, bus_idle, cfg_wr_req,
           cfg_prop_seg_fd, cfg_phase_seg_1_fd, cfg_phase_seg_2_fd,
           cfg_baud_r_presc_fd, cfg_sjw_fd, cfg_triple_sampling_fd,
    input  cfg_wr_ack, cfg_wr_err, prop_seg_fd, phase_seg_1_fd, phase_seg_2_fd,
           baud_r_presc_fd, sjw_fd, triple_sampling_fd, data_phase, fd_frame,
           brs_on, brs_off, data_bit_cnt, wdog_timeout, dbg_state
  );

  modport slave (
    input  sample_point, sampled_bit, en_FD_rx, sof_bit, fdf_bit, brs_bit,
           crc_delim_bit, go_error_frame, bus_idle, cfg_wr_req,
           cfg_prop_seg_fd, cfg_phase_seg_1_fd, cfg_phase_seg_2_fd,
           cfg_baud_r_presc_fd, cfg_sjw_fd, cfg_triple_sampling_fd,
    output cfg_wr_ack, cfg_wr_err, prop_seg_fd, phase_seg_1_fd, phase_seg_2_fd,
           baud_r_presc_fd, sjw_fd, triple_sampling_fd, data_phase, fd_frame,
           brs_on, brs_off, data_bit_cnt, wdog_timeout, dbg_state
  );
endinterface

// File: rtl/can_brs_ctrl.sv
// CAN FD receive bit-rate switch: frame phase tracking, data_phase control and
// idle-only FD timing update. Define CAN_BRS_WDOG_EN to enable the data-phase watchdog.
module can_brs_ctrl #(
  parameter int unsigned MAX_DATA_BITS = 1023
) (
  input logic          clk,
  input logic          rst,
  can_brs_ctrl_if.slave bus
);

`ifdef CAN_BRS_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_NOM, S_FD_NOM, S_DATA, S_TAIL} state_e;

  state_e     state_q, state_d;
  logic       data_phase_q, data_phase_d;
  logic       fd_frame_q, fd_frame_d;
  logic       brs_on_q, brs_on_d, brs_off_q, brs_off_d;
  logic [9:0] cnt_q, cnt_d;
  logic       wdog_q, wdog_d;
  logic       armed_q, armed_d;
  logic       ack_q, ack_d, err_q, err_d;
  logic [5:0] prop_q, prop_d;
  logic [4:0] ps1_q, ps1_d, ps2_q, ps2_d, sjw_q, sjw_d;
  logic [6:0] presc_q, presc_d;
  logic       trip_q, trip_d;
  logic       wdog_hit, service, cfg_ok;

  // Frame phase FSM: error frame beats bus idle, which beats sample-point moves.
  always_comb begin
    state_d  = state_q;
    wdog_hit = WDOG_EN && (state_q == S_DATA) && bus.sample_point &&
               ((32'(cnt_q) + 32'd1) >= MAX_DATA_BITS);
    if (bus.go_error_frame) begin
      state_d = S_IDLE;
    end else if (bus.bus_idle && (state_q inside {S_NOM, S_FD_NOM, S_TAIL})) begin
      state_d = S_IDLE;
    end else if (bus.sample_point) begin
      case (state_q)
        S_IDLE:   if (bus.sof_bit) state_d = S_NOM;
        S_NOM:    if (bus.fdf_bit && bus.sampled_bit && bus.en_FD_rx) state_d = S_FD_NOM;
        S_FD_NOM: if (bus.brs_bit && bus.sampled_bit) state_d = S_DATA;
        S_DATA:   if (bus.crc_delim_bit || wdog_hit) state_d = S_TAIL;
        default:  ;
      endcase
    end
  end

  // cfg_wr_req is a level request, serviced once per assertion while idle;
  // the result is a one-cycle cfg_wr_ack (applied) or cfg_wr_err (rejected).
  always_comb begin
    data_phase_d = (state_d == S_DATA);
    brs_on_d     = data_phase_d && !data_phase_q;
    brs_off_d    = data_phase_q && !data_phase_d;

    fd_frame_d = fd_frame_q;
    if (state_d == S_IDLE)                              fd_frame_d = 1'b0;
    else if (state_q == S_NOM && state_d == S_FD_NOM)   fd_frame_d = 1'b1;

    cnt_d = cnt_q;
    if (state_d == S_DATA && state_q != S_DATA)          cnt_d = '0;
    else if (state_q == S_DATA && bus.sample_point && cnt_q != 10'd1023)
      cnt_d = cnt_q + 10'd1;

    service = bus.cfg_wr_req && armed_q && (state_q == S_IDLE) && !data_phase_q;
    cfg_ok  = (bus.cfg_phase_seg_2_fd >= bus.cfg_sjw_fd) && (bus.cfg_phase_seg_2_fd != 5'd0);
    ack_d   = service && cfg_ok;
    err_d   = service && !cfg_ok;

    armed_d = armed_q;
    if (!bus.cfg_wr_req) armed_d = 1'b1;
    else if (service)    armed_d = 1'b0;

    prop_d  = prop_q;
    ps1_d   = ps1_q;
    ps2_d   = ps2_q;
    sjw_d   = sjw_q;
    presc_d = presc_q;
    trip_d  = trip_q;
    if (ack_d) begin
      prop_d  = bus.cfg_prop_seg_fd;
      ps1_d   = bus.cfg_phase_seg_1_fd;
      ps2_d   = bus.cfg_phase_seg_2_fd;
      sjw_d   = bus.cfg_sjw_fd;
      presc_d = bus.cfg_baud_r_presc_fd;
      trip_d  = bus.cfg_triple_sampling_fd;
    end

    wdog_d = wdog_q;
    if (ack_d)         wdog_d = 1'b0;
    else if (wdog_hit) wdog_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      data_phase_q <= 1'b0;
      fd_frame_q   <= 1'b0;
      brs_on_q     <= 1'b0;
      brs_off_q    <= 1'b0;
      cnt_q        <= '0;
      wdog_q       <= 1'b0;
      armed_q      <= 1'b1;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      prop_q       <= 6'd1;
      ps1_q        <= 5'd3;
      ps2_q        <= 5'd2;
      sjw_q        <= 5'd1;
      presc_q      <= 7'd0;
      trip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_phase_q <= data_phase_d;
      fd_frame_q   <= fd_frame_d;
      brs_on_q     <= brs_on_d;
      brs_off_q    <= brs_off_d;
      cnt_q        <= cnt_d;
      wdog_q       <= wdog_d;
      armed_q      <= armed_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      prop_q       <= prop_d;
      ps1_q        <= ps1_d;
      ps2_q        <= ps2_d;
      sjw_q        <= sjw_d;
      presc_q      <= presc_d;
      trip_q       <= trip_d;
    end
  end

  assign bus.data_phase         = data_phase_q;
  assign bus.fd_frame           = fd_frame_q;
  assign bus.brs_on             = brs_on_q;
  assign bus.brs_off            = brs_off_q;
  assign bus.data_bit_cnt       = cnt_q;
  assign bus.wdog_timeout       = wdog_q;
  assign bus.cfg_wr_ack         = ack_q;
  assign bus.cfg_wr_err         = err_q;
  assign bus.prop_seg_fd        = prop_q;
  assign bus.phase_seg_1_fd     = ps1_q;
  assign bus.phase_seg_2_fd     = ps2_q;
  assign bus.sjw_fd             = sjw_q;
  assign bus.baud_r_presc_fd    = presc_q;
  assign bus.triple_sampling_fd = trip_q;
  assign bus.dbg_state          = state_q;

endmodule

// File: tb/tb_can_brs_ctrl.sv
// Bench for can_brs_ctrl: frames described by their field outcomes, expectations
// derived per frame from where the data phase starts and ends.
module tb_can_brs_ctrl;
  localparam int MAXB = 16;
`ifdef CAN_BRS_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  can_brs_ctrl_if bus();
  can_brs_ctrl #(.MAX_DATA_BITS(MAXB)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       exp_dp, exp_on, exp_off, exp_fd, exp_ack, exp_err, exp_wd, exp_trip;
  logic [9:0] exp_cnt;
  logic [5:0] exp_prop;
  logic [4:0] exp_ps1, exp_ps2, exp_sjw;
  logic [6:0] exp_presc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_reset_model();
    exp_dp = 0; exp_on = 0; exp_off = 0; exp_fd = 0; exp_ack = 0; exp_err = 0;
    exp_wd = 0; exp_cnt = '0;
    exp_prop = 6'd1; exp_ps1 = 5'd3; exp_ps2 = 5'd2; exp_sjw = 5'd1;
    exp_presc = 7'd0; exp_trip = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_phase"}, 32'(bus.data_phase), 32'(exp_dp));
    chk({tag, ".brs_on"},     32'(bus.brs_on),     32'(exp_on));
    chk({tag, ".brs_off"},    32'(bus.brs_off),    32'(exp_off));
    chk({tag, ".fd_frame"},   32'(bus.fd_frame),   32'(exp_fd));
    chk({tag, ".cnt"},        32'(bus.data_bit_cnt), 32'(exp_cnt));
    chk({tag, ".wdog"},       32'(bus.wdog_timeout), 32'(exp_wd));
    chk({tag, ".ack"},        32'(bus.cfg_wr_ack), 32'(exp_ack));
    chk({tag, ".err"},        32'(bus.cfg_wr_err), 32'(exp_err));
    chk({tag, ".timing"},
        {bus.prop_seg_fd, bus.phase_seg_1_fd, bus.phase_seg_2_fd, bus.sjw_fd,
         bus.baud_r_presc_fd, bus.triple_sampling_fd},
        {exp_prop, exp_ps1, exp_ps2, exp_sjw, exp_presc, exp_trip});
    exp_on = 0; exp_off = 0; exp_ack = 0; exp_err = 0;
  endtask

  task automatic clear_strobes();
    bus.sample_point = 0; bus.sof_bit = 0; bus.fdf_bit = 0; bus.brs_bit = 0;
    bus.crc_delim_bit = 0; bus.go_error_frame = 0; bus.bus_idle = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    clear_strobes();
    check_all(tag);
  endtask

  task automatic sp_step(input string tag);
    bus.sample_point = 1;
    step(tag);
    repeat ($urandom_range(0, 2)) step("gap");
  endtask

  task automatic set_cfg(input logic [4:0] ps2, input logic [4:0] sjw);
    bus.cfg_prop_seg_fd        = 6'($urandom);
    bus.cfg_phase_seg_1_fd     = 5'($urandom);
    bus.cfg_phase_seg_2_fd     = ps2;
    bus.cfg_sjw_fd             = sjw;
    bus.cfg_baud_r_presc_fd    = 7'($urandom);
    bus.cfg_triple_sampling_fd = 1'($urandom);
  endtask

  // Expected outcome of an applied request: the new values become active.
  task automatic model_cfg_result();
    if (bus.cfg_phase_seg_2_fd >= bus.cfg_sjw_fd && bus.cfg_phase_seg_2_fd != 0) begin
      exp_prop  = bus.cfg_prop_seg_fd;     exp_ps1 = bus.cfg_phase_seg_1_fd;
      exp_ps2   = bus.cfg_phase_seg_2_fd;  exp_sjw = bus.cfg_sjw_fd;
      exp_presc = bus.cfg_baud_r_presc_fd; exp_trip = bus.cfg_triple_sampling_fd;
      exp_ack = 1; exp_wd = 0;
    end else begin
      exp_err = 1;
    end
  endtask

  task automatic cfg_write(input logic [4:0] ps2, input logic [4:0] sjw);
    set_cfg(ps2, sjw);
    bus.cfg_wr_req = 1;
    model_cfg_result();
    step("cfg_req");
    step("cfg_held");
    bus.cfg_wr_req = 0;
    step("cfg_drop");
  endtask

  // One received frame. n_data counts sample points after BRS up to and
  // including the CRC delimiter; err_at / rst_at pick a data sample point
  // (1-based) for an error frame or an asynchronous reset (0 = none).
  task automatic run_frame(input bit fdf, input bit en, input bit brs, input int n_data,
                           input int err_at, input int rst_at, input bit mid_req);
    bit fd, in_data;
    fd = fdf && en;
    in_data = 0;
    bus.en_FD_rx = en;
    bus.sof_bit = 1; bus.sampled_bit = 0;
    sp_step("sof");
    repeat ($urandom_range(3, 6)) begin bus.sampled_bit = 1'($urandom); sp_step("arb"); end
    bus.fdf_bit = 1; bus.sampled_bit = fdf; exp_fd = fd;
    sp_step("fdf");
    repeat ($urandom_range(1, 2)) begin bus.sampled_bit = 1'($urandom); sp_step("res"); end
    bus.brs_bit = 1; bus.sampled_bit = brs;
    if (fd && brs) begin in_data = 1; exp_dp = 1; exp_on = 1; exp_cnt = '0; end
    sp_step("brs");
    if (mid_req) bus.cfg_wr_req = 1;
    for (int i = 1; i <= n_data; i++) begin
      if (i == rst_at) begin
        #2 rst = 0;
        #1 set_reset_model();
        check_all("async_rst");
        #2 rst = 1;
        clear_strobes();
        return;
      end
      bus.crc_delim_bit = (i == n_data);
      bus.go_error_frame = (i == err_at);
      bus.sampled_bit = 1'($urandom);
      if (in_data) begin
        exp_cnt = 10'(i);
        if (i == n_data || i == err_at || (WD_EN && i == MAXB)) begin
          in_data = 0; exp_dp = 0; exp_off = 1;
          if (WD_EN && i == MAXB) exp_wd = 1;
        end
      end
      if (i == err_at) begin
        exp_fd = 0;
        sp_step("err");
        break;
      end
      sp_step("data");
    end
    if (err_at == 0) repeat (2) begin bus.sampled_bit = 1'($urandom); sp_step("tail"); end
    bus.bus_idle = 1; exp_fd = 0;
    step("bus_idle");
  endtask

  initial begin
    rst = 0;
    clear_strobes();
    bus.sampled_bit = 0; bus.en_FD_rx = 0; bus.cfg_wr_req = 0;
    set_cfg(5'd2, 5'd1);
    set_reset_model();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    rst = 1;
    step("idle0");

    // FD frames with and without the switch, classic frames
    run_frame(1, 1, 1, 40, 0, 0, 0);
    run_frame(1, 1, 0, 20, 0, 0, 0);
    run_frame(1, 0, 1, 20, 0, 0, 0);
    run_frame(0, 1, 1, 12, 0, 0, 0);
    // error frame on the 10th data sample point
    run_frame(1, 1, 1, 30, 10, 0, 0);
    chk("err_cnt_hold", 32'(bus.data_bit_cnt), 32'd10);

    // configuration: accepted, rejected, zero segment, boundary ps2 == sjw
    cfg_write(5'd4, 5'd2);
    cfg_write(5'd1, 5'd2);
    cfg_write(5'd0, 5'd0);
    cfg_write(5'd7, 5'd7);

    // request raised mid data phase is served only once the bus is idle
    set_cfg(5'd6, 5'd3);
    run_frame(1, 1, 1, 25, 0, 0, 1);
    model_cfg_result();
    step("cfg_late");
    bus.cfg_wr_req = 0;
    step("cfg_late_drop");

    // long data phase: watchdog exit when enabled, plain count otherwise
    run_frame(1, 1, 1, 30, 0, 0, 0);
    step("wdog_sticky");
    cfg_write(5'd9, 5'd4);

    // asynchronous reset in the middle of the data phase
    run_frame(1, 1, 1, 30, 0, 12, 0);
    step("post_rst");

    for (int f = 0; f < 12; f++) begin
      int nd, ea;
      nd = $urandom_range(1, 40);
      if (nd == MAXB) nd++;
      ea = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nd) : 0;
      if (ea == MAXB) ea--;
      run_frame(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), nd, ea, 0, 0);
      if ($urandom_range(0, 2) == 0) cfg_write(5'($urandom), 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
